// File: rtl/credit_fifo_pkg.sv
// Shared types and constants for the credit-based FIFO.
// The skid occupancy type covers 0..SKID_DEPTH; data widths stay module parameters.
package credit_fifo_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] skid_occ_t;

endpackage

// File: rtl/credit_fifo_scdpram_infer.sv
// Single-clock simple dual-port RAM, inferred, with a registered read port.
// Ports: clk; write port we/waddr/wdata; read port re/raddr -> rdata one cycle later.
// READ_NEW_DATA=0 returns the old word on a same-address read/write collision.
module scdpram_infer #(
    parameter int WIDTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int DEPTH         = 2 ** ADDR_WIDTH,
    parameter int READ_NEW_DATA = 0,
    parameter     RAMSTYLE      = "M20K"
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] ram_q;

    if (RAMSTYLE == "MLAB") begin : g_mlab
        (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (re) ram_q <= mem[raddr];
        end
    end else begin : g_m20k
        (* ramstyle = "M20K" *) logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (re) ram_q <= mem[raddr];
        end
    end

    if (READ_NEW_DATA != 0) begin : g_new
        // Forward the write data when a read hits the address being written.
        logic             byp_q;
        logic [WIDTH-1:0] byp_data_q;

        always_ff @(posedge clk) begin
            if (re) begin
                byp_q      <= we && (waddr == raddr);
                byp_data_q <= wdata;
            end
        end

        assign rdata = byp_q ? byp_data_q : ram_q;
    end else begin : g_old
        assign rdata = ram_q;
    end

endmodule

// File: rtl/credit_fifo.sv
// Credit-flow-controlled FIFO: DEPTH-entry RAM feeding a 2-entry output skid buffer.
// Ports: clock, reset (sync, high); in_valid/in_data upstream; credit_out credit return;
// out_valid/out_data/out_ready downstream; count words held; overflow sticky violation.
module credit_fifo
    import credit_fifo_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter     RAMSTYLE   = "M20K"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  credit_out,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0]   FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_occ_q, ram_occ_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    skid_occ_t             skid_occ_q, skid_occ_d;
    logic                  inflight_q, inflight_d;
    logic [WORD_WIDTH-1:0] skid0_q, skid0_d;
    logic [WORD_WIDTH-1:0] skid1_q, skid1_d;
    logic                  credit_q, credit_d;
    logic                  overflow_q, overflow_d;

    logic                  wr_en;
    logic                  rd_en;
    logic                  fire;
    logic                  full;
    logic [2:0]            skid_load;
    logic [WORD_WIDTH-1:0] rd_data;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full       = (count_q == FULL);
        fire       = (skid_occ_q != '0) && out_ready;
        wr_en      = in_valid && !full;
        // Skid slots already claimed after this cycle's pop; a new read may
        // only issue if its data will find a free slot when it lands.
        skid_load  = 3'(skid_occ_q) + 3'(inflight_q) - 3'(fire);
        rd_en      = (ram_occ_q != '0) && (skid_load < 3'(SKID_DEPTH));

        wptr_d     = wr_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d     = rd_en ? ptr_inc(rptr_q) : rptr_q;
        // Only earlier-cycle writes are readable, so a read never collides
        // with the word being written this cycle.
        ram_occ_d  = ram_occ_q + (ADDR_WIDTH + 1)'(wr_en)
                               - (ADDR_WIDTH + 1)'(rd_en);
        count_d    = count_q + (ADDR_WIDTH + 1)'(wr_en)
                             - (ADDR_WIDTH + 1)'(fire);
        inflight_d = rd_en;
        credit_d   = fire;
        overflow_d = overflow_q || (in_valid && full);

        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_occ_d = skid_occ_q;
        case ({fire, inflight_q})
            2'b10: begin
                skid0_d    = skid1_q;
                skid_occ_d = skid_occ_q - 1'b1;
            end
            2'b01: begin
                if (skid_occ_q == '0) skid0_d = rd_data;
                else                  skid1_d = rd_data;
                skid_occ_d = skid_occ_q + 1'b1;
            end
            2'b11: begin
                if (skid_occ_q == 2'd1) begin
                    skid0_d = rd_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_occ_q  <= '0;
            count_q    <= '0;
            skid_occ_q <= '0;
            inflight_q <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_occ_q  <= ram_occ_d;
            count_q    <= count_d;
            skid_occ_q <= skid_occ_d;
            inflight_q <= inflight_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    scdpram_infer #(
        .WIDTH        (WORD_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DEPTH        (DEPTH),
        .READ_NEW_DATA(0),
        .RAMSTYLE     (RAMSTYLE)
    ) u_ram (
        .clk  (clock),
        .we   (wr_en),
        .waddr(wptr_q),
        .wdata(in_data),
        .re   (rd_en),
        .raddr(rptr_q),
        .rdata(rd_data)
    );

    assign credit_out = credit_q;
    assign out_valid  = (skid_occ_q != '0);
    assign out_data   = skid0_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule
